// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer: feeds signed 8x8 operand pairs to an external
// shift-add multiplier, accumulates LENGTH sign-extended products and
// emits the dot product with a one-cycle ResultValid strobe.
module dot_product_sequencer #(
    parameter int unsigned LENGTH    = 4,
    parameter int unsigned ACC_WIDTH = 20
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [7:0]           InA,
    input  logic [7:0]           InB,
    output logic                 MulStart,
    output logic [7:0]           MulA,
    output logic [7:0]           MulB,
    input  logic [15:0]          MulProduct,
    input  logic                 MulDone,
    output logic [ACC_WIDTH-1:0] Result,
    output logic                 ResultValid,
    output logic                 Busy,
    output logic [3:0]           Count
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    localparam logic [3:0] LEN4 = 4'(LENGTH);

    state_t                 state_q, state_d;
    logic [7:0]             mul_a_q, mul_a_d;
    logic [7:0]             mul_b_q, mul_b_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [3:0]             count_q, count_d;
    logic [ACC_WIDTH-1:0]   result_q, result_d;
    logic                   mul_done_q;
    logic                   done_rise;
    logic [ACC_WIDTH-1:0]   prod_ext;

    // Only a fresh rising edge of Done counts, so a level-style Done left
    // high from the previous multiply cannot complete the next one early.
    assign done_rise = MulDone & ~mul_done_q;
    assign prod_ext  = ACC_WIDTH'(signed'(MulProduct));

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d     = state_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        acc_d       = acc_q;
        count_d     = count_q;
        result_d    = result_q;
        InReady     = 1'b0;
        MulStart    = 1'b0;
        ResultValid = 1'b0;
        case (state_q)
            IDLE: begin
                InReady = ~Reset;
                if (InValid) begin
                    mul_a_d = InA;
                    mul_b_d = InB;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                MulStart = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    acc_d   = acc_q + prod_ext;
                    count_d = count_q + 4'd1;
                    // Result is loaded on the completion edge so it is
                    // already valid during the FINISH strobe cycle.
                    if (count_d == LEN4) begin
                        result_d = acc_d;
                        state_d  = FINISH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FINISH: begin
                ResultValid = 1'b1;
                acc_d       = '0;
                count_d     = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    // Registered copy of MulDone, tracked in every state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            mul_done_q <= 1'b0;
        end else begin
            mul_done_q <= MulDone;
        end
    end

    assign MulA   = mul_a_q;
    assign MulB   = mul_b_q;
    assign Result = result_q;
    assign Count  = count_q;
    assign Busy   = (state_q != IDLE);

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: behavioural SAM model plus a result
// scoreboard drained by an independent monitor.
module tb_dot_product_sequencer;

    localparam int LEN = 4;
    localparam int AW  = 20;
    localparam int LAT = 9;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          InValid = 1'b0;
    logic          InReady;
    logic [7:0]    InA = '0;
    logic [7:0]    InB = '0;
    logic          MulStart;
    logic [7:0]    MulA;
    logic [7:0]    MulB;
    logic [15:0]   MulProduct;
    logic          MulDone;
    logic [AW-1:0] Result;
    logic          ResultValid;
    logic          Busy;
    logic [3:0]    Count;

    int n_checks = 0;
    int n_errors = 0;
    int n_starts = 0;
    int n_accepts = 0;
    int n_rdy_viol = 0;
    int exp_q[$];
    int count_log[$];
    bit log_en = 1'b0;
    logic [3:0] prev_cnt = '0;
    int mode = 0; // 0 level Done, 1 pulse Done, 2 stale level Done

    always #5 Clock = ~Clock;

    dot_product_sequencer #(.LENGTH(LEN), .ACC_WIDTH(AW)) dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .InA(InA), .InB(InB), .MulStart(MulStart), .MulA(MulA), .MulB(MulB),
        .MulProduct(MulProduct), .MulDone(MulDone), .Result(Result),
        .ResultValid(ResultValid), .Busy(Busy), .Count(Count)
    );

    // Behavioural shift-add multiplier with fixed latency
    logic signed [15:0] sa, sb;
    int sam_cnt;
    logic sam_busy;
    always @(posedge Clock) begin
        if (Reset) begin
            MulDone <= 1'b0; MulProduct <= '0; sam_busy <= 1'b0; sam_cnt <= 0;
            sa <= '0; sb <= '0;
        end else if (MulStart) begin
            sam_busy <= 1'b1;
            sam_cnt  <= LAT;
            sa <= {{8{MulA[7]}}, MulA};
            sb <= {{8{MulB[7]}}, MulB};
            if (mode != 2) MulDone <= 1'b0;
        end else if (sam_busy) begin
            sam_cnt <= sam_cnt - 1;
            if (mode == 2 && sam_cnt == LAT - 3) MulDone <= 1'b0;
            if (sam_cnt == 1) begin
                MulProduct <= sa * sb;
                MulDone    <= 1'b1;
                sam_busy   <= 1'b0;
            end
        end else if (mode == 1) begin
            MulDone <= 1'b0;
        end
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge Clock) begin
        if (!Reset && ResultValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_result: got %0d expected none", $signed(Result));
            end else begin
                check("result", $signed(Result), exp_q.pop_front());
            end
        end
    end

    // Protocol observers
    always @(negedge Clock) begin
        if (!Reset) begin
            if (MulStart) n_starts++;
            if (InReady && Busy) n_rdy_viol++;
        end
        if (log_en && Count != prev_cnt) count_log.push_back(int'(Count));
        prev_cnt = Count;
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit hold);
        int t = 0;
        @(negedge Clock);
        while (!InReady && t < 200) begin
            @(negedge Clock);
            t++;
        end
        if (!InReady) begin
            n_checks++; n_errors++;
            $display("FAIL send_timeout: got InReady=0 expected 1");
            InValid = 1'b0;
            return;
        end
        InValid = 1'b1; InA = a; InB = b;
        @(posedge Clock);
        n_accepts++;
        #1;
        if (!hold) InValid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge Clock);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_checks++; n_errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge Clock);
    endtask

    initial begin
        int t;
        int k;
        int sum;
        int s0;
        logic signed [7:0] ra, rb;

        // Reset values
        repeat (3) @(posedge Clock);
        #1;
        check("rst_inready", InReady, 0);
        check("rst_busy", Busy, 0);
        check("rst_mulstart", MulStart, 0);
        check("rst_resultvalid", ResultValid, 0);
        check("rst_count", Count, 0);
        check("rst_result", Result, 0);
        check("rst_mula", MulA, 0);
        check("rst_mulb", MulB, 0);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("inready_after_reset", InReady, 1);

        // Basic vector, level Done
        log_en = 1'b1;
        exp_q.push_back(16489);
        send(8'd12, 8'd10, 0);
        send(-8'sd5, 8'd3, 0);
        send(8'h80, 8'h80, 0);
        send(8'd7, 8'd0, 0);
        drain();
        log_en = 1'b0;
        check("count_log_len", count_log.size(), 5);
        if (count_log.size() == 5) begin
            check("count_seq0", count_log[0], 1);
            check("count_seq1", count_log[1], 2);
            check("count_seq2", count_log[2], 3);
            check("count_seq3", count_log[3], 4);
            check("count_seq4", count_log[4], 0);
        end

        // Back-to-back vectors with InValid held high
        s0 = n_starts;
        exp_q.push_back(24);
        exp_q.push_back(60);
        repeat (4) send(8'hFF, 8'hFA, 1);
        repeat (3) send(8'd5, 8'd3, 1);
        send(8'd5, 8'd3, 0);
        drain();
        check("starts_per_pair", n_starts - s0, 8);
        check("inready_only_idle", n_rdy_viol, 0);

        // Pulse-style Done
        mode = 1;
        exp_q.push_back(-143);
        send(8'd150, 8'd2, 0);
        send(-8'sd5, 8'd3, 0);
        send(8'd12, 8'd7, 0);
        send(8'd0, 8'hFF, 0);
        drain();

        // Stale level Done held into the next operation
        mode = 2;
        exp_q.push_back(99);
        send(8'd3, 8'd4, 0);
        send(8'd2, -8'sd7, 0);
        send(8'hFF, 8'hFF, 0);
        send(8'd10, 8'd10, 0);
        drain();

        // Reset in WAIT after two completed pairs
        mode = 0;
        send(8'd2, 8'd3, 0);
        send(8'd4, 8'd5, 0);
        t = 0;
        while (Count != 4'd2 && t < 100) begin
            @(negedge Clock);
            t++;
        end
        check("count_before_abort", Count, 2);
        send(8'd6, 8'd7, 0);
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        #1;
        check("inready_in_reset", InReady, 0);
        @(negedge Clock);
        Reset = 1'b0;
        check("abort_busy", Busy, 0);
        check("abort_count", Count, 0);
        check("abort_mulstart", MulStart, 0);
        check("abort_resultvalid", ResultValid, 0);
        exp_q.push_back(4);
        repeat (4) send(8'd1, 8'd1, 0);
        drain();

        // Random InValid with operands changing while not ready
        k = 0; sum = 0; t = 0;
        while (k < 2 * LEN && t < 3000) begin
            @(negedge Clock);
            t++;
            InValid = 1'($urandom_range(0, 1));
            InA = 8'($urandom);
            InB = 8'($urandom);
            if (InValid && InReady) begin
                ra = InA; rb = InB;
                sum += int'(ra) * int'(rb);
                k++;
                n_accepts++;
                if (k % LEN == 0) begin
                    exp_q.push_back(sum);
                    sum = 0;
                end
            end
        end
        @(posedge Clock);
        #1;
        InValid = 1'b0;
        check("random_pairs_accepted", k, 2 * LEN);
        drain();

        check("inready_only_idle_total", n_rdy_viol, 0);
        check("starts_vs_accepts", n_starts, n_accepts);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
